// File: rtl/event_timestamper.sv
// Event timestamper: edge-detects evt_i, stamps each event with the free-running counter,
// computes the wrap-safe interval to the previous event and queues records in a show-ahead FIFO.
module event_timestamper #(
    parameter int CNT_W  = 20,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [CNT_W-1:0]         cnt_in,
    input  logic                     evt_i,
    input  logic                     clear_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_ts,
    output logic [CNT_W-1:0]         out_delta,
    output logic                     out_first,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 2 * CNT_W + 1;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic                 evt_q;
    logic                 armed_first;
    logic [CNT_W-1:0]     last_ts;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [DROP_W-1:0]    drop_q;
    logic                 ovf_q;
    logic [REC_W-1:0]     mem [DEPTH];
    logic [REC_W-1:0]     head;

    logic                 capture;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 first_c;
    logic [CNT_W-1:0]     delta_c;

    // Capture stage: edge detect, interval and FIFO handshake decisions
    always_comb begin
        capture = evt_i && !evt_q;
        full    = (count == (AW + 1)'(DEPTH));
        pop     = out_valid && out_ready;
        push    = capture && !clear_i && (!full || pop);
        drop    = capture && !clear_i && full && !pop;
        first_c = armed_first;
        delta_c = armed_first ? '0 : cnt_in - last_ts;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_q       <= 1'b0;
            armed_first <= 1'b1;
            last_ts     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            evt_q <= evt_i;
            if (clear_i) begin
                // last_ts deliberately survives a flush so later deltas stay meaningful
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                drop_q      <= '0;
                ovf_q       <= 1'b0;
                armed_first <= 1'b1;
            end else begin
                if (capture) begin
                    last_ts     <= cnt_in;
                    armed_first <= 1'b0;
                end
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW + 1)'(1);
                    2'b01:   count <= count - (AW + 1)'(1);
                    default: count <= count;
                endcase
                if (drop) begin
                    drop_q <= sat_inc(drop_q);
                    ovf_q  <= 1'b1;
                end
            end
        end
    end

    // Storage stage: record RAM, data path only
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {first_c, delta_c, cnt_in};
    end

    // Output stage: show-ahead head, zeroed while empty
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count != '0);
        out_ts    = out_valid ? head[CNT_W-1:0]       : '0;
        out_delta = out_valid ? head[2*CNT_W-1:CNT_W] : '0;
        out_first = out_valid ? head[REC_W-1]         : 1'b0;
        level     = count;
        drop_cnt  = drop_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_event_timestamper.sv
// Bench for event_timestamper: directed vector table, hand sequences for fill/drop/reset,
// and random traffic against a queue-based reference model.
module tb_event_timestamper;

    localparam int CNT_W  = 20;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [CNT_W-1:0]  cnt_in;
    logic              evt_i;
    logic              clear_i;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_ts;
    logic [CNT_W-1:0]  out_delta;
    logic              out_first;
    logic [3:0]        level;
    logic [DROP_W-1:0] drop_cnt;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    event_timestamper #(.CNT_W(CNT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .evt_i(evt_i), .clear_i(clear_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_delta(out_delta), .out_first(out_first), .level(level),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] ts;
        logic [CNT_W-1:0] delta;
        logic             first;
    } rec_t;

    rec_t             q[$];
    logic             m_evq;
    logic             m_armed;
    logic [CNT_W-1:0] m_last;
    int               m_drop;
    logic             m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_evq = 1'b0; m_armed = 1'b1; m_last = '0; m_drop = 0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic r, input logic c,
                              input logic [CNT_W-1:0] cn);
        bit   cap, pp;
        int   sz;
        rec_t rec;
        cap = e && !m_evq;
        sz  = q.size();
        pp  = (sz != 0) && r;
        if (c) begin
            q.delete(); m_drop = 0; m_ovf = 1'b0; m_armed = 1'b1;
        end else begin
            if (pp) void'(q.pop_front());
            if (cap) begin
                rec.ts    = cn;
                rec.first = m_armed;
                rec.delta = m_armed ? '0 : cn - m_last;
                m_last    = cn;
                m_armed   = 1'b0;
                if (sz < DEPTH || pp) q.push_back(rec);
                else begin
                    if (m_drop != 255) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
        m_evq = e;
    endtask

    task automatic check_model();
        chk("m_valid", out_valid, q.size() != 0);
        chk("m_level", level, q.size());
        chk("m_drop", drop_cnt, m_drop);
        chk("m_ovf", overflow, m_ovf);
        if (q.size() != 0) begin
            chk("m_ts", out_ts, q[0].ts);
            chk("m_delta", out_delta, q[0].delta);
            chk("m_first", out_first, q[0].first);
        end
    endtask

    // Drive inputs just after a falling edge, advance one clock, check at the next falling edge.
    task automatic cycle(input logic e, input logic r, input logic c, input logic [CNT_W-1:0] cn);
        evt_i = e; out_ready = r; clear_i = c; cnt_in = cn;
        model_step(e, r, c, cn);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic             evt, rdy, clr;
        logic [CNT_W-1:0] cnt;
        logic             ev;
        logic [CNT_W-1:0] ets, edl;
        logic             ef;
        int               elv;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [CNT_W-1:0] cnt_r;
        logic             rdy_bias;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 20'd9,      1'b0, 20'd0,      20'd0,      1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 20'd10,     1'b1, 20'd10,     20'd0,      1'b1, 1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 20'd11,     1'b0, 20'd0,      20'd0,      1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 20'd24,     1'b0, 20'd0,      20'd0,      1'b0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 20'd25,     1'b1, 20'd25,     20'd15,     1'b0, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 20'd26,     1'b0, 20'd0,      20'd0,      1'b0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 20'hFFFF0,  1'b0, 20'd0,      20'd0,      1'b0, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 20'hFFFF0,  1'b1, 20'hFFFF0,  20'hFFFD7,  1'b0, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 20'h00005,  1'b0, 20'd0,      20'd0,      1'b0, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 20'h00010,  1'b1, 20'h00010,  20'h00020,  1'b0, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 20'h00011,  1'b1, 20'h00010,  20'h00020,  1'b0, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 20'h00012,  1'b1, 20'h00010,  20'h00020,  1'b0, 1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 20'h00020,  1'b1, 20'h00020,  20'h00010,  1'b0, 1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 20'h00021,  1'b0, 20'd0,      20'd0,      1'b0, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 20'h00030,  1'b1, 20'h00030,  20'd0,      1'b1, 1};

        rstn = 1'b0; evt_i = 1'b0; out_ready = 1'b0; clear_i = 1'b0; cnt_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ts", out_ts, 0);
        chk("rst_delta", out_delta, 0);
        chk("rst_first", out_first, 0);
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].evt, tbl[i].rdy, tbl[i].clr, tbl[i].cnt);
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("vec%0d_level", i), level, tbl[i].elv);
            chk($sformatf("vec%0d_drop", i), drop_cnt, 0);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_ts", i), out_ts, tbl[i].ets);
                chk($sformatf("vec%0d_delta", i), out_delta, tbl[i].edl);
                chk($sformatf("vec%0d_first", i), out_first, tbl[i].ef);
            end
        end

        // evt_i held high yields a single capture
        cycle(1'b0, 1'b1, 1'b1, 20'd50);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 20'(60 + i));
        cycle(1'b0, 1'b0, 1'b0, 20'd70);
        cycle(1'b1, 1'b0, 1'b0, 20'd71);
        chk("held_level", level, 2);

        // Overfill: 10 events into 8 entries
        cycle(1'b0, 1'b1, 1'b1, 20'd90);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 20'(100 + 10 * k));
            cycle(1'b0, 1'b0, 1'b0, 20'(101 + 10 * k));
        end
        chk("fill_level", level, 8);
        chk("fill_drop", drop_cnt, 2);
        chk("fill_ovf", overflow, 1);
        chk("fill_head_ts", out_ts, 100);
        chk("fill_head_first", out_first, 1);

        // Full, popping and capturing in the same cycle
        cycle(1'b1, 1'b1, 1'b0, 20'd300);
        chk("fullpp_level", level, 8);
        chk("fullpp_drop", drop_cnt, 2);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), out_valid, 1);
            chk($sformatf("drain%0d_ts", i), out_ts, (i < 7) ? 110 + 10 * i : 300);
            chk($sformatf("drain%0d_delta", i), out_delta, (i < 7) ? 10 : 110);
            chk($sformatf("drain%0d_first", i), out_first, 0);
            cycle(1'b0, 1'b1, 1'b0, 20'(400 + i));
        end
        chk("drain_level", level, 0);

        // Asynchronous reset mid-stream
        cycle(1'b0, 1'b0, 1'b1, 20'd480);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_ovf", overflow, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 20'(500 + 10 * k));
            cycle(1'b0, 1'b0, 1'b0, 20'(505 + 10 * k));
        end
        chk("pre_rst_level", level, 5);
        evt_i = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 20'd700);
        chk("rel_valid", out_valid, 1);
        chk("rel_ts", out_ts, 700);
        chk("rel_first", out_first, 1);
        chk("rel_delta", out_delta, 0);

        // Clear mid-stream re-arms first
        cycle(1'b0, 1'b0, 1'b0, 20'd710);
        cycle(1'b1, 1'b0, 1'b0, 20'd720);
        cycle(1'b0, 1'b0, 1'b1, 20'd730);
        chk("clr2_level", level, 0);
        chk("clr2_drop", drop_cnt, 0);
        cycle(1'b1, 1'b1, 1'b0, 20'd745);
        chk("clr2_first", out_first, 1);
        chk("clr2_delta", out_delta, 0);

        // Random traffic against the reference model
        cnt_r = 20'd800;
        rdy_bias = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) rdy_bias = ~rdy_bias;
            if ($urandom_range(0, 499) == 0) cnt_r = 20'hFFFE0 + 20'($urandom_range(0, 15));
            else cnt_r = cnt_r + 20'($urandom_range(1, 3));
            cycle($urandom_range(0, 9) < 4,
                  rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 99) == 0,
                  cnt_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_timestamper.md
Name: event_timestamper

Overview:
- Downstream consumer of the free-running 20-bit cycle counter.
- Edge-detects an event input and captures the counter value on each event as a timestamp.
- Computes the modulo-2^CNT_W interval since the previous event.
- Buffers {first, delta, timestamp} records in a show-ahead FIFO drained through a valid/ready interface, e.g. by a debug/trace readout or CSR block.

Parameters:
CNT_W, 20, width of counter input, timestamp and delta.
DEPTH, 8, FIFO entries; power of 2, >= 2.
DROP_W, 8, width of saturating dropped-event counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rstn  input  1  asynchronous active-low reset.
cnt_in  input  CNT_W  current counter value (counter `out`).
evt_i  input  1  event level; capture on 0->1 transition.
clear_i  input  1  synchronous flush: empties FIFO, clears drop/overflow state, re-arms first.
out_valid  output  1  head record available.
out_ready  input  1  consumer accepts head when out_valid && out_ready.
out_ts  output  CNT_W  head timestamp.
out_delta  output  CNT_W  head interval to previous event.
out_first  output  1  head is first event since reset/clear.
level  output  clog2(DEPTH)+1  entries currently stored.
drop_cnt  output  DROP_W  events lost to full FIFO; saturates at all-ones.
overflow  output  1  sticky; set on any drop.

Behaviour:
- Async reset (rstn low):
  - Outputs: out_valid=0, level=0, drop_cnt=0, overflow=0, out_ts/out_delta/out_first=0.
  - Internal state: evt_q=0, last_ts=0, armed_first=1, pointers=0.
  - Takes effect immediately, without waiting for clk; a FIFO in mid-operation is discarded.
- Edge detect:
  - evt_q registers evt_i.
  - capture = evt_i && !evt_q.
  - evt_i held high yields one capture; evt_i already high when reset is released captures on the first clock.
- Capture in cycle N:
  - ts = cnt_in sampled at that edge.
  - delta = (cnt_in - last_ts) mod 2^CNT_W; wrap-around is natural unsigned subtraction.
  - If armed_first: delta = 0, first = 1, armed_first cleared; otherwise first = 0.
  - last_ts <= cnt_in on every capture, including dropped ones, so deltas always reference the true previous event.
- FIFO (show-ahead):
  - Push on capture when not full, or when full but a pop occurs in the same cycle.
  - A record pushed at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1) if the FIFO was empty.
  - Pop when out_valid && out_ready; the next head appears the following cycle.
  - Simultaneous push/pop: level unchanged.
  - out_* hold stable while out_valid && !out_ready.
- Drop:
  - Condition: capture while level==DEPTH and no pop in that cycle.
  - Record discarded; drop_cnt += 1 (saturating); overflow <= 1.
  - first flag consumed even if the record is dropped.
- clear_i (synchronous, priority over push/pop that cycle):
  - level=0, out_valid=0, drop_cnt=0, overflow=0, armed_first=1.
  - last_ts unchanged.
  - A capture coinciding with clear_i is discarded; evt_q still updates.
- level: exact occupancy, 0..DEPTH.

Test Plan:
- Counter running from reset, out_ready=1, evt_i pulses at cnt_in=10 and 25 -> records (ts=10, delta=0, first=1) then (ts=25, delta=15, first=0); each out_valid one cycle after capture.
- Wrap: events at cnt_in=0xFFFF0 then 0x00010 -> second record delta=0x00020.
- evt_i held high 5 cycles, then low, then high -> exactly 2 records.
- out_ready=0, 10 distinct events with DEPTH=8 -> level=8, drop_cnt=2, overflow=1. Then drain -> 8 records in order; record 9's delta is relative to the dropped event 10's predecessor chain (last_ts = event 10).
- FIFO full with out_ready=1 and capture in the same cycle -> push accepted, level stays 8, drop_cnt unchanged.
- rstn low asynchronously mid-stream with level=5 -> out_valid=0 and level=0 before the next edge. After release, clear_i pulse mid-stream -> level=0, drop_cnt=0, next record first=1.
